// File: rtl/iob_bus_split_pipe.sv
// iob_bus_split_pipe: N-way IOb splitter with pipelined, in-order response routing.
// Define IOB_BUS_SPLIT_ERR_EN to add an internal error target for out-of-range selects.
module iob_bus_split_pipe #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = 2,
    parameter int P_MSB    = ADDR_W - 1,
    parameter int MAX_OUT  = 4,
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W  = DATA_W + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_W-1:0]             m_req,
    output logic [RESP_W-1:0]            m_resp,
    output logic [N_SLAVES*REQ_W-1:0]    s_req,
    input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
    output logic                         busy,
    output logic                         err
);
    // One extra index bit so the error target (index N_SLAVES) always fits
    localparam int T_W = SEL_W + 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam logic [T_W-1:0] NT = T_W'(N_SLAVES);
    localparam logic [CNT_W-1:0] MO = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [T_W-1:0] cur_sel_q, sel, tgt;
    logic [2**T_W-1:0] t_rdy, t_rv;
    logic [DATA_W-1:0] t_rd [2**T_W];
    logic avalid, allowed, ready, rvalid;

    assign avalid = m_req[REQ_W-1];
    assign sel = {1'b0, m_req[REQ_W-1-ADDR_W+P_MSB -: SEL_W]};

`ifdef IOB_BUS_SPLIT_ERR_EN
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'({(DATA_W + 31) / 32{32'hDEADBEEF}});
    logic err_hit, err_q, err_rv_q;
    assign err_hit = sel >= NT;
    assign tgt = err_hit ? NT : sel;
    assign err = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            err_rv_q <= 1'b0;
        end else begin
            err_rv_q <= ready & err_hit;
            err_q <= err_q | (ready & err_hit);
        end
    end
`else
    localparam logic [T_W-1:0] NL = T_W'(N_SLAVES - 1);
    assign tgt = (sel >= NT) ? NL : sel;
    assign err = 1'b0;
`endif

    always_comb begin
        t_rdy = '0;
        t_rv = '0;
        for (int k = 0; k < 2**T_W; k++) t_rd[k] = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            t_rdy[k] = s_resp[k*RESP_W];
            t_rv[k] = s_resp[k*RESP_W+1];
            t_rd[k] = s_resp[k*RESP_W+2 +: DATA_W];
        end
`ifdef IOB_BUS_SPLIT_ERR_EN
        t_rdy[N_SLAVES] = 1'b1;
        t_rv[N_SLAVES] = err_rv_q;
        t_rd[N_SLAVES] = ERR_DATA;
`endif
    end

    // Switching targets waits for a drained pipe, which keeps responses in order
    assign allowed = ~rst & avalid & ((cnt_q == '0) | (tgt == cur_sel_q & cnt_q < MO));
    assign ready = allowed & t_rdy[tgt];
    assign rvalid = ~rst & (cnt_q != '0) & t_rv[cur_sel_q];
    assign m_resp = {{DATA_W{rvalid}} & t_rd[cur_sel_q], rvalid, ready};
    assign busy = cnt_q != '0;
    assign cnt_d = cnt_q + CNT_W'(ready) - CNT_W'(rvalid);

    always_comb begin
        s_req = '0;
        for (int k = 0; k < N_SLAVES; k++)
            if (allowed && tgt == T_W'(k)) s_req[k*REQ_W +: REQ_W] = m_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            cur_sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (ready) cur_sel_q <= tgt;
        end
    end
endmodule

// File: tb/tb_iob_bus_split_pipe.sv
// tb_iob_bus_split_pipe: scoreboard bench for the N-way IOb splitter (N_SLAVES=3, MAX_OUT=4).
module tb_iob_bus_split_pipe;
    localparam int AW = 32, DW = 32, NS = 3, SW = 2, MO = 4;
    localparam int REQ_W = 1 + AW + DW + DW / 8, RESP_W = DW + 2;
`ifdef IOB_BUS_SPLIT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {int k; int due; logic [DW-1:0] d;} pend_t;

    logic clk = 1'b0;
    logic rst, nrst, busy, err;
    logic [REQ_W-1:0] m_req, nreq;
    logic [RESP_W-1:0] m_resp, st_resp;
    logic [NS*REQ_W-1:0] s_req, st_sreq;
    logic [NS*RESP_W-1:0] s_resp;
    logic st_busy, st_err;

    pend_t pq[$];
    logic [DW-1:0] sb[$];
    logic [REQ_W-1:0] rq[$];
    logic [NS-1:0] s_rdy;
    int lat[NS];
    logic [DW-1:0] sdata[NS];
    logic [DW-1:0] last_rd;
    logic [31:0] va, vr, vb, vz, ve;
    logic [NS-1:0] vs[32];
    int cyc, mcnt, pkc, n_chk, n_bad;

    always #5 clk = ~clk;

    iob_bus_split_pipe #(
        .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .SEL_W(SW), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .busy(busy), .err(err)
    );

    function automatic logic [REQ_W-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [3:0] ws);
        return {1'b1, a, wd, ws};
    endfunction

    function automatic int tgt_of(input logic [AW-1:0] a);
        int s = int'(a[31:30]);
        return s < NS ? s : (ERR_EN ? NS : NS - 1);
    endfunction

    // One clock: drive at negedge, sample 1ns later, update slave models and scoreboard
    task automatic step(output logic acc, output logic rv);
        int hk[NS];
        int t;
        logic [REQ_W-1:0] slice;
        logic [DW-1:0] exp_d;
        pend_t p;
        @(negedge clk);
        m_req = nreq;
        rst = nrst;
        s_resp = '0;
        for (int k = 0; k < NS; k++) begin
            hk[k] = -1;
            for (int i = 0; i < pq.size(); i++)
                if (pq[i].k == k) begin
                    hk[k] = i;
                    break;
                end
            s_resp[k*RESP_W] = s_rdy[k];
            if (hk[k] >= 0 && pq[hk[k]].due <= cyc) begin
                s_resp[k*RESP_W+1] = 1'b1;
                s_resp[k*RESP_W+2 +: DW] = pq[hk[k]].d;
            end else hk[k] = -1;
        end
        #1;
        st_resp = m_resp;
        st_sreq = s_req;
        st_busy = busy;
        st_err = err;
        acc = m_req[REQ_W-1] & m_resp[0];
        rv = m_resp[1];
        t = tgt_of(m_req[REQ_W-2 -: AW]);
        for (int k = 0; k < NS; k++) begin
            slice = s_req[k*REQ_W +: REQ_W];
            n_chk++;
            if (!(slice === '0 || (k == t && slice === m_req)) || (acc && k == t && slice !== m_req)) begin
                n_bad++;
                $display("FAIL route cyc=%0d slave=%0d got=%h exp=%h", cyc, k, slice, (k == t) ? m_req : '0);
            end
        end
        n_chk++;
        if (!rv && m_resp[RESP_W-1:2] !== '0) begin
            n_bad++;
            $display("FAIL rdata_gate cyc=%0d got=%h exp=0", cyc, m_resp[RESP_W-1:2]);
        end
        n_chk++;
        if (st_busy !== (mcnt != 0)) begin
            n_bad++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, st_busy, mcnt != 0);
        end
        if (rv) begin
            n_chk++;
            last_rd = m_resp[RESP_W-1:2];
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_rvalid cyc=%0d got=%h exp=none", cyc, last_rd);
            end else begin
                exp_d = sb.pop_front();
                if (last_rd !== exp_d) begin
                    n_bad++;
                    $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, last_rd, exp_d);
                end
            end
        end
        if (acc) begin
            if (t < NS) begin
                p.k = t;
                p.due = cyc + lat[t];
                p.d = sdata[t];
                pq.push_back(p);
                sb.push_back(sdata[t]);
                sdata[t]++;
            end else sb.push_back(32'hDEADBEEF);
        end
        for (int i = pq.size() - 1; i >= 0; i--)
            for (int k = 0; k < NS; k++)
                if (hk[k] == i) pq.delete(i);
        mcnt = mcnt + (acc ? 1 : 0) - (rv ? 1 : 0);
        if (mcnt > pkc) pkc = mcnt;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mcnt = 0;
            sb.delete();
        end
    endtask

    // Issue the queued requests back to back, holding each until accepted, and record per-cycle flags
    task automatic run(input int n, input int rst_at);
        logic a, r;
        va = '0; vr = '0; vb = '0; vz = '0; ve = '0;
        pkc = 0;
        for (int o = 0; o < n; o++) begin
            nreq = (rq.size() != 0) ? rq[0] : '0;
            nrst = (o == rst_at);
            step(a, r);
            if (a) void'(rq.pop_front());
            va[o] = a;
            vr[o] = r;
            vb[o] = st_busy;
            vz[o] = |st_resp | |st_sreq;
            ve[o] = st_err;
            for (int k = 0; k < NS; k++) vs[o][k] = st_sreq[k*REQ_W+REQ_W-1];
        end
        nreq = '0;
        nrst = 1'b0;
        rq.delete();
    endtask

    task automatic drain();
        int n = 0;
        logic a, r;
        nreq = '0;
        while ((sb.size() != 0 || pq.size() != 0 || mcnt != 0) && n < 40) begin
            step(a, r);
            n++;
        end
        n_chk++;
        if (n >= 40) begin
            n_bad++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size() + pq.size());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic a, r;
        nrst = 1'b1;
        nreq = mk(32'h4000_0000, 32'h0, 4'h0);
        step(a, r);
        step(a, r);
        n_chk++;
        if (st_resp !== '0 || st_sreq !== '0 || st_busy !== 1'b0 || st_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", st_resp, st_busy, st_err);
        end
        nrst = 1'b0;
        nreq = '0;
        step(a, r);
        chk("reset_idle_resp", 32'(|st_resp | |st_sreq), 32'h0);
    endtask

    task automatic test_single();
        logic [NS*REQ_W-1:0] exp_s;
        sdata[1] = 32'h1234_5678;
        rq.push_back(mk(32'h4000_0010, 32'h0, 4'h0));
        run(4, -1);
        exp_s = '0;
        exp_s[REQ_W +: REQ_W] = mk(32'h4000_0010, 32'h0, 4'h0);
        chk("single_acc", va[3:0], 32'b0001);
        chk("single_rvalid", vr[3:0], 32'b0010);
        chk("single_busy", vb[3:0], 32'b0010);
        chk("single_slave_valid", 32'(vs[0]), 32'b010);
        chk("single_rdata", last_rd, 32'h1234_5678);
        drain();
    endtask

    task automatic test_back_to_back();
        lat[0] = 4;
        for (int i = 0; i < 5; i++) rq.push_back(mk(32'h0000_0100 + 32'(i * 4), 32'h0, 4'h0));
        run(12, -1);
        chk("b2b_acc", va[11:0], 32'b0000_0010_1111);
        chk("b2b_rvalid", vr[11:0], 32'b0010_1111_0000);
        chk("b2b_busy", vb[11:0], 32'b0011_1111_1110);
        chk("b2b_full_stall", {30'(vs[4]), 1'b0, va[4]}, 32'h0);
        chk("b2b_peak", 32'(pkc), 32'd4);
        drain();
        lat[0] = 1;
    endtask

    task automatic test_switch();
        logic [7:0] v2;
        lat[0] = 3;
        rq.push_back(mk(32'h0000_0200, 32'h0, 4'h0));
        rq.push_back(mk(32'h8000_0000, 32'hCAFE_F00D, 4'hF));
        run(8, -1);
        for (int o = 0; o < 8; o++) v2[o] = vs[o][2];
        chk("switch_acc", va[7:0], 32'b0001_0001);
        chk("switch_s2_valid", 32'(v2), 32'b0001_0000);
        chk("switch_rvalid", vr[7:0], 32'b0010_1000);
        drain();
        lat[0] = 1;
    endtask

    task automatic test_simul();
        lat[1] = 2;
        for (int i = 0; i < 3; i++) rq.push_back(mk(32'h4000_0300 + 32'(i * 4), 32'h0, 4'h0));
        run(7, -1);
        chk("simul_acc", va[6:0], 32'b000_0111);
        chk("simul_rvalid", vr[6:0], 32'b001_1100);
        chk("simul_busy", vb[6:0], 32'b001_1110);
        drain();
        lat[1] = 1;
    endtask

    task automatic test_err();
        sdata[2] = 32'h55AA_0001;
        rq.push_back(mk(32'hC000_0000, 32'h0, 4'h0));
        run(5, -1);
        chk("oor_acc", va[4:0], 32'b00001);
        chk("oor_rvalid", vr[4:0], 32'b00010);
        chk("oor_slave_valid", 32'(vs[0]), ERR_EN ? 32'b000 : 32'b100);
        chk("oor_rdata", last_rd, ERR_EN ? 32'hDEAD_BEEF : 32'h55AA_0001);
        chk("oor_err", ve[4:0], ERR_EN ? 32'b11110 : 32'b00000);
        drain();
    endtask

    task automatic test_reset_mid();
        lat[0] = 5;
        for (int i = 0; i < 3; i++) rq.push_back(mk(32'h0000_0400 + 32'(i * 4), 32'h0, 4'h0));
        run(10, 3);
        chk("rstmid_acc", va[9:0], 32'b00_0000_0111);
        chk("rstmid_rvalid", vr[9:0], 32'b0);
        chk("rstmid_busy", vb[9:0], 32'b00_0000_1110);
        chk("rstmid_quiet", vz[9:4], 32'b0);
        chk("rstmid_err", ve[9:4], 32'b0);
        drain();
        lat[0] = 1;
    endtask

    initial begin
        rst = 1'b1;
        nrst = 1'b1;
        m_req = '0;
        nreq = '0;
        s_resp = '0;
        s_rdy = '1;
        lat = '{1, 1, 1};
        for (int k = 0; k < NS; k++) sdata[k] = 32'h1000_0000 * 32'(k + 1);
        last_rd = '0;
        cyc = 0;
        mcnt = 0;
        pkc = 0;
        n_chk = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_switch();
        test_simul();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
